// File: rtl/accel_pkg.sv
// Shared types and default widths for the systolic MAC array.
package accel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        FLUSH,
        DRAIN
    } state_t;

    localparam int DEF_ROWS       = 4;
    localparam int DEF_COLS       = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_KLEN_WIDTH = 16;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: a MAC plus a/b forwarding registers with valid bits.
// SYSTOLIC_MAC_SATURATE_EN selects clamping accumulation instead of wrapping.
module systolic_pe
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic                  a_in_valid,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  b_in_valid,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  a_out_valid,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  b_out_valid,
`ifdef SYSTOLIC_MAC_SATURATE_EN
    output logic                  sat,
`endif
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [DATA_WIDTH:0] a_ext, b_ext;
    logic signed [PW-1:0]       prod;
    logic                       fire;
    logic [ACC_WIDTH-1:0]       acc_next;

    assign fire  = a_in_valid & b_in_valid;
    assign a_ext = {signed_mode & a_in[DATA_WIDTH-1], a_in};
    assign b_ext = {signed_mode & b_in[DATA_WIDTH-1], b_in};
    // Low PW bits of the extended product are exact for both modes.
    assign prod  = PW'(a_ext) * PW'(b_ext);

`ifdef SYSTOLIC_MAC_SATURATE_EN
    logic [ACC_WIDTH:0] acc_x, prod_x, sum;
    logic               ovf;

    assign acc_x  = {signed_mode & acc[ACC_WIDTH-1], acc};
    assign prod_x = signed_mode ? (ACC_WIDTH+1)'(prod) : (ACC_WIDTH+1)'($unsigned(prod));
    assign sum    = acc_x + prod_x;
    assign ovf    = signed_mode ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
    assign sat    = fire & ovf;

    always_comb begin
        // NOTE: every path starts from a default, so no latch is inferred.
        acc_next = sum[ACC_WIDTH-1:0];
        if (ovf) begin
            if (!signed_mode)       acc_next = '1;
            else if (sum[ACC_WIDTH]) acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            else                    acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    logic [ACC_WIDTH-1:0] prod_x;

    assign prod_x   = signed_mode ? ACC_WIDTH'(prod) : ACC_WIDTH'($unsigned(prod));
    assign acc_next = acc + prod_x;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the accumulator is a plain register, not a memory, so it takes the async reset.
        if (!rst_n) begin
            a_out       <= '0;
            a_out_valid <= 1'b0;
            b_out       <= '0;
            b_out_valid <= 1'b0;
            acc         <= '0;
        end else begin
            // NOTE: non-blocking so each neighbour samples this PE's pre-edge value.
            a_out       <= a_in;
            a_out_valid <= a_in_valid;
            b_out       <= b_in;
            b_out_valid <= b_in_valid;
            if (clear)     acc <= '0;
            else if (fire) acc <= acc_next;
        end
    end

endmodule

// File: rtl/systolic_mac_array.sv
// ROWSxCOLS output-stationary systolic MAC array with skew, FSM and row drain.
// Define SYSTOLIC_MAC_SATURATE_EN for saturating accumulation and a live sat_flag.
module systolic_mac_array
    import accel_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int KLEN_WIDTH = DEF_KLEN_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KLEN_WIDTH-1:0]      k_len,
    input  logic                       signed_mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] a_vec,
    input  logic [COLS*DATA_WIDTH-1:0] b_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*ACC_WIDTH-1:0]  out_row,
    output logic [$clog2(ROWS)-1:0]    out_row_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       sat_flag
);

    localparam int IDX_W     = $clog2(ROWS);
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FC_W      = $clog2(FLUSH_LEN + 1);

    state_t                  state, state_next;
    logic [KLEN_WIDTH-1:0]   k_len_r, beat_cnt;
    logic                    signed_r;
    logic [FC_W-1:0]         flush_cnt;
    logic [IDX_W-1:0]        row_idx;
    logic                    start_ok, accept, last_beat, flush_end, row_hs, last_row;

    assign in_ready    = (state == COMPUTE);
    assign out_valid   = (state == DRAIN);
    assign busy        = (state != IDLE);
    assign out_row_idx = row_idx;

    assign start_ok  = (state == IDLE) && start;
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (beat_cnt == k_len_r - 1'b1);
    assign flush_end = (state == FLUSH) && (flush_cnt == FC_W'(FLUSH_LEN - 1));
    assign row_hs    = out_valid && out_ready;
    assign last_row  = row_hs && (row_idx == IDX_W'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (k_len == '0) ? DRAIN : COMPUTE;
            COMPUTE: if (last_beat) state_next = FLUSH;
            FLUSH:   if (flush_end) state_next = DRAIN;
            DRAIN:   if (last_row) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_len_r   <= '0;
            signed_r  <= 1'b0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= last_row;
            if (start_ok) begin
                k_len_r   <= k_len;
                signed_r  <= signed_mode;
                beat_cnt  <= '0;
                flush_cnt <= '0;
                row_idx   <= '0;
            end
            if (accept)           beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
            if (state == FLUSH)   flush_cnt <= flush_end ? '0 : flush_cnt + 1'b1;
            if (row_hs)           row_idx   <= last_row ? '0 : row_idx + 1'b1;
        end
    end

    logic [DATA_WIDTH-1:0] a_h  [ROWS][COLS+1];
    logic                  a_hv [ROWS][COLS+1];
    logic [DATA_WIDTH-1:0] b_v  [ROWS+1][COLS];
    logic                  b_vv [ROWS+1][COLS];
    logic [ACC_WIDTH-1:0]  acc_m [ROWS][COLS];
    logic [ROWS*COLS-1:0]  sat_m;

    // Row i enters i cycles late so its beats meet column j's beats on the diagonal.
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign a_h[0][0]  = a_vec[0 +: DATA_WIDTH];
            assign a_hv[0][0] = accept;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] d [0:i-1];
            logic                  v [0:i-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < i; k++) begin d[k] <= '0; v[k] <= 1'b0; end
                end else begin
                    d[0] <= a_vec[i*DATA_WIDTH +: DATA_WIDTH];
                    v[0] <= accept;
                    for (int k = 1; k < i; k++) begin d[k] <= d[k-1]; v[k] <= v[k-1]; end
                end
            end
            assign a_h[i][0]  = d[i-1];
            assign a_hv[i][0] = v[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign b_v[0][0]  = b_vec[0 +: DATA_WIDTH];
            assign b_vv[0][0] = accept;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] d [0:j-1];
            logic                  v [0:j-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < j; k++) begin d[k] <= '0; v[k] <= 1'b0; end
                end else begin
                    d[0] <= b_vec[j*DATA_WIDTH +: DATA_WIDTH];
                    v[0] <= accept;
                    for (int k = 1; k < j; k++) begin d[k] <= d[k-1]; v[k] <= v[k-1]; end
                end
            end
            assign b_v[0][j]  = d[j-1];
            assign b_vv[0][j] = v[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            systolic_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk         (clk),
                .rst_n       (rst_n),
                .clear       (start_ok),
                .signed_mode (signed_r),
                .a_in        (a_h[i][j]),
                .a_in_valid  (a_hv[i][j]),
                .b_in        (b_v[i][j]),
                .b_in_valid  (b_vv[i][j]),
                .a_out       (a_h[i][j+1]),
                .a_out_valid (a_hv[i][j+1]),
                .b_out       (b_v[i+1][j]),
                .b_out_valid (b_vv[i+1][j]),
`ifdef SYSTOLIC_MAC_SATURATE_EN
                .sat         (sat_m[i*COLS+j]),
`endif
                .acc         (acc_m[i][j])
            );
`ifndef SYSTOLIC_MAC_SATURATE_EN
            assign sat_m[i*COLS+j] = 1'b0;
`endif
        end
    end

`ifdef SYSTOLIC_MAC_SATURATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        sat_flag <= 1'b0;
        else if (start_ok) sat_flag <= 1'b0;
        else if (|sat_m)   sat_flag <= 1'b1;
    end
`else
    assign sat_flag = 1'b0;
`endif

    always_comb begin
        out_row = '0;
        if (out_valid) begin
            for (int j = 0; j < COLS; j++) out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_m[row_idx][j];
        end
    end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Self-checking bench: a default-width array and a 16-bit-accumulator array share stimulus
// and are both compared with a beat-by-beat arithmetic reference model.
module tb_systolic_mac_array;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int KW   = 16;
    localparam int MAXK = 64;
`ifdef SYSTOLIC_MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n, start, signed_mode, in_valid, out_ready;
    logic [KW-1:0]        k_len;
    logic [ROWS*DW-1:0]   a_vec;
    logic [COLS*DW-1:0]   b_vec;

    logic                 in_ready_32, out_valid_32, busy_32, done_32, sat_32;
    logic [COLS*32-1:0]   row_32;
    logic [1:0]           idx_32;
    logic                 in_ready_16, out_valid_16, busy_16, done_16, sat_16;
    logic [COLS*16-1:0]   row_16;
    logic [1:0]           idx_16;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] ta [MAXK][ROWS];
    logic [DW-1:0] tb [MAXK][COLS];

    always #5 clk = ~clk;

    systolic_mac_array dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready_32), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid_32), .out_ready(out_ready), .out_row(row_32),
        .out_row_idx(idx_32), .busy(busy_32), .done(done_32), .sat_flag(sat_32)
    );

    systolic_mac_array #(.ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready_16), .a_vec(a_vec), .b_vec(b_vec),
        .out_valid(out_valid_16), .out_ready(out_ready), .out_row(row_16),
        .out_row_idx(idx_16), .busy(busy_16), .done(done_16), .sat_flag(sat_16)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: accumulate true products beat by beat, clamp per beat when saturating.
    function automatic longint model_acc(int i, int j, int klen, bit sm, int w, output bit satf);
        longint acc = 0;
        longint av, bv, lo, hi;
        satf = 1'b0;
        lo = sm ? -(longint'(1) << (w - 1)) : 0;
        hi = sm ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
        for (int k = 0; k < klen; k++) begin
            av = sm ? longint'($signed(ta[k][i])) : longint'(ta[k][i]);
            bv = sm ? longint'($signed(tb[k][j])) : longint'(tb[k][j]);
            acc += av * bv;
            if (SAT && acc > hi) begin acc = hi; satf = 1'b1; end
            if (SAT && acc < lo) begin acc = lo; satf = 1'b1; end
        end
        return acc & ((longint'(1) << w) - 1);
    endfunction

    function automatic logic [COLS*32-1:0] exp_row32(int r, int klen, bit sm);
        logic [COLS*32-1:0] row;
        longint v;
        bit f;
        for (int j = 0; j < COLS; j++) begin
            v = model_acc(r, j, klen, sm, 32, f);
            row[j*32 +: 32] = v[31:0];
        end
        return row;
    endfunction

    function automatic logic [COLS*16-1:0] exp_row16(int r, int klen, bit sm);
        logic [COLS*16-1:0] row;
        longint v;
        bit f;
        for (int j = 0; j < COLS; j++) begin
            v = model_acc(r, j, klen, sm, 16, f);
            row[j*16 +: 16] = v[15:0];
        end
        return row;
    endfunction

    function automatic bit exp_sat(int klen, bit sm, int w);
        bit any = 1'b0;
        bit f;
        longint v;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                v = model_acc(i, j, klen, sm, w, f);
                any |= f;
            end
        return any;
    endfunction

    task automatic fill_const(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int k = 0; k < MAXK; k++) begin
            for (int i = 0; i < ROWS; i++) ta[k][i] = a;
            for (int j = 0; j < COLS; j++) tb[k][j] = b;
        end
    endtask

    task automatic fill_index();
        for (int k = 0; k < MAXK; k++) begin
            for (int i = 0; i < ROWS; i++) ta[k][i] = DW'(i + 1);
            for (int j = 0; j < COLS; j++) tb[k][j] = DW'(j + 1);
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < MAXK; k++) begin
            for (int i = 0; i < ROWS; i++) ta[k][i] = DW'($urandom);
            for (int j = 0; j < COLS; j++) tb[k][j] = DW'($urandom);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_in_ready"},  {in_ready_32, in_ready_16}, 2'b00);
        check({tag, "_out_valid"}, {out_valid_32, out_valid_16}, 2'b00);
        check({tag, "_busy"},      {busy_32, busy_16}, 2'b00);
        check({tag, "_done"},      {done_32, done_16}, 2'b00);
        check({tag, "_sat"},       {sat_32, sat_16}, 2'b00);
        check({tag, "_row32"},     row_32, '0);
        check({tag, "_row16"},     row_16, '0);
        check({tag, "_idx"},       {idx_32, idx_16}, 4'b0000);
    endtask

    // vmode: 0 = in_valid held high, 1 = 1,0,0,1,1,0,1 pattern, 2 = random bubbles.
    task automatic do_tile(input string name, input int klen, input bit sm, input int vmode,
                           input int stall, input bit hold_start);
        int idx, cyc, n, p;
        bit acc_now;
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        @(negedge clk);
        start = 1'b1; k_len = KW'(klen); signed_mode = sm; in_valid = 1'b0;
        @(posedge clk);
        idx = 0; cyc = 0; p = 0;
        while (idx < klen && cyc < 1000) begin
            @(negedge clk);
            start       = hold_start;
            k_len       = KW'($urandom_range(0, 9));
            signed_mode = 1'($urandom);
            case (vmode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = pat[p % 7]; p++; end
                default: in_valid = 1'($urandom);
            endcase
            for (int i = 0; i < ROWS; i++) a_vec[i*DW +: DW] = in_valid ? ta[idx][i] : DW'($urandom);
            for (int j = 0; j < COLS; j++) b_vec[j*DW +: DW] = in_valid ? tb[idx][j] : DW'($urandom);
            if (cyc == 0) check({name, "_compute_ready"}, {busy_32, in_ready_32, in_ready_16}, 3'b111);
            acc_now = in_valid && in_ready_32;
            @(posedge clk);
            if (acc_now) idx++;
            cyc++;
        end
        check({name, "_beats_accepted"}, idx, klen);

        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        if (klen > 0) check({name, "_ready_drop"}, {in_ready_32, in_ready_16}, 2'b00);
        while (!out_valid_32 && n < 50) begin
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
        check({name, "_flush_cycles"}, n, (klen > 0) ? ROWS + COLS - 1 : 0);

        for (int r = 0; r < ROWS; r++) begin
            out_ready = 1'b1;
            if (r == 1 && stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    check({name, "_stall_idx"},   {idx_32, idx_16}, {2'(r), 2'(r)});
                    check({name, "_stall_row32"}, row_32, exp_row32(r, klen, sm));
                    check({name, "_stall_row16"}, row_16, exp_row16(r, klen, sm));
                    @(posedge clk);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check($sformatf("%s_valid_r%0d", name, r), {out_valid_32, out_valid_16}, 2'b11);
            check($sformatf("%s_idx_r%0d", name, r),   {idx_32, idx_16}, {2'(r), 2'(r)});
            check($sformatf("%s_row32_r%0d", name, r), row_32, exp_row32(r, klen, sm));
            check($sformatf("%s_row16_r%0d", name, r), row_16, exp_row16(r, klen, sm));
            if (r == 0) check({name, "_sat"}, {sat_32, sat_16},
                              {exp_sat(klen, sm, 32), exp_sat(klen, sm, 16)});
            @(posedge clk);
            @(negedge clk);
        end
        check({name, "_done_pulse"}, {done_32, done_16, busy_32, busy_16, out_valid_32}, 5'b11000);
        out_ready = 1'b0;
        @(negedge clk);
        check({name, "_done_clear"}, {done_32, done_16}, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0; signed_mode = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a_vec = '0; b_vec = '0;
        #1;
        check_idle_zero("in_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("after_reset");

        fill_const(8'd1, 8'd2);
        do_tile("ones_by_twos", 4, 1'b0, 0, 0, 1'b0);

        fill_const(8'h80, 8'h80);
        do_tile("neg128_sq", 2, 1'b1, 0, 0, 1'b0);

        fill_const(8'hFF, 8'h01);
        do_tile("neg1_by_1", 2, 1'b1, 0, 0, 1'b0);

        fill_index();
        do_tile("bubbles_stall", 4, 1'b0, 1, 5, 1'b1);

        fill_const(8'd127, 8'd127);
        do_tile("sat_signed", 3, 1'b1, 0, 0, 1'b0);

        fill_const(8'd255, 8'd255);
        do_tile("sat_unsigned", 2, 1'b0, 2, 2, 1'b0);

        for (int t = 0; t < 4; t++) begin
            fill_rand();
            do_tile($sformatf("rand%0d", t), $urandom_range(1, 12), 1'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end

        fill_rand();
        @(negedge clk);
        start = 1'b1; k_len = 16'd4; signed_mode = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        a_vec = {ROWS{8'h33}}; b_vec = {COLS{8'h44}};
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_mid_reset");

        do_tile("klen_zero", 0, 1'b0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
